// File: rtl/stage_ex_if.sv
// ID -> EX handshake, register-file operands, WB bypass and EX/MEM outputs.
// The master modport is the ID/pipeline-control side; the slave is the stage.
interface stage_ex_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    logic              in_valid;
    logic              in_ready;
    logic              stall;
    logic              flush;
    logic [31:0]       id_pc;
    logic [5:0]        id_opcode;
    logic [5:0]        id_funct;
    logic [REG_W-1:0]  id_rs;
    logic [REG_W-1:0]  id_rt;
    logic [REG_W-1:0]  id_rd;
    logic [DATA_W-1:0] id_rd1;
    logic [DATA_W-1:0] id_rd2;
    logic [DATA_W-1:0] id_imm;
    logic              wb_valid;
    logic [REG_W-1:0]  wb_reg;
    logic [DATA_W-1:0] wb_data;
    logic              ex_valid;
    logic [31:0]       ex_pc;
    logic [DATA_W-1:0] ex_alu_result;
    logic [DATA_W-1:0] ex_store_data;
    logic [REG_W-1:0]  ex_dest_reg;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic              ex_illegal;
    logic              ex_hazard;

    modport master (
        output in_valid, stall, flush, id_pc, id_opcode, id_funct, id_rs, id_rt, id_rd,
               id_rd1, id_rd2, id_imm, wb_valid, wb_reg, wb_data,
        input  in_ready, ex_valid, ex_pc, ex_alu_result, ex_store_data, ex_dest_reg,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal, ex_hazard
    );
    modport slave (
        input  in_valid, stall, flush, id_pc, id_opcode, id_funct, id_rs, id_rt, id_rd,
               id_rd1, id_rd2, id_imm, wb_valid, wb_reg, wb_data,
        output in_ready, ex_valid, ex_pc, ex_alu_result, ex_store_data, ex_dest_reg,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal, ex_hazard
    );
endinterface

// File: rtl/stage_ex.sv
// MIPS execute stage: ID/EX register, forwarding ALU, load-use bubble, EX/MEM register.
// Decode happens on the ID/EX contents so held entries re-evaluate forwarding every cycle.
module stage_ex #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic     clk,
    input  logic     rst_n,
    stage_ex_if.slave bus
);
    localparam logic [5:0] OP_RTYPE = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24,
                           FN_OR  = 6'h25, FN_SLT = 6'h2A;

    logic              r_de_valid;
    logic [31:0]       r_de_pc;
    logic [5:0]        r_de_opcode, r_de_funct;
    logic [REG_W-1:0]  r_de_rs, r_de_rt, r_de_rd;
    logic [DATA_W-1:0] r_de_rd1, r_de_rd2, r_de_imm;

    logic              r_em_valid, r_em_reg_write, r_em_mem_read, r_em_mem_write, r_em_illegal;
    logic [31:0]       r_em_pc;
    logic [DATA_W-1:0] r_em_result, r_em_store;
    logic [REG_W-1:0]  r_em_dest;

    logic              w_hazard;
    logic [DATA_W-1:0] w_a, w_b, w_result, w_store;
    logic [REG_W-1:0]  w_dest;
    logic              w_rw, w_mr, w_mw, w_ill;

    // Loads are excluded from EX/MEM bypass: their data only exists after MEM.
    function automatic logic [DATA_W-1:0] fwd(input logic [REG_W-1:0] src,
                                              input logic [DATA_W-1:0] latched);
        if (r_em_valid && r_em_reg_write && !r_em_mem_read && r_em_dest != '0 && r_em_dest == src)
            return r_em_result;
        else if (bus.wb_valid && bus.wb_reg != '0 && bus.wb_reg == src)
            return bus.wb_data;
        else
            return latched;
    endfunction

    assign w_hazard = r_de_valid && r_em_valid && r_em_mem_read && r_em_dest != '0 &&
                      (r_em_dest == r_de_rs || r_em_dest == r_de_rt);
    assign w_a = fwd(r_de_rs, r_de_rd1);
    assign w_b = fwd(r_de_rt, r_de_rd2);

    always_comb begin
        w_result = '0;
        w_store  = w_b;
        w_dest   = '0;
        w_rw     = 1'b0;
        w_mr     = 1'b0;
        w_mw     = 1'b0;
        w_ill    = 1'b0;
        case (r_de_opcode)
            OP_RTYPE: begin
                w_dest = r_de_rd;
                w_rw   = 1'b1;
                case (r_de_funct)
                    FN_ADD:  w_result = w_a + w_b;
                    FN_SUB:  w_result = w_a - w_b;
                    FN_AND:  w_result = w_a & w_b;
                    FN_OR:   w_result = w_a | w_b;
                    FN_SLT:  w_result = {{(DATA_W-1){1'b0}}, $signed(w_a) < $signed(w_b)};
                    default: begin
                        w_dest  = '0;
                        w_rw    = 1'b0;
                        w_ill   = 1'b1;
                        w_store = '0;
                    end
                endcase
            end
            OP_LW: begin
                w_result = w_a + r_de_imm;
                w_dest   = r_de_rt;
                w_rw     = 1'b1;
                w_mr     = 1'b1;
            end
            OP_SW: begin
                w_result = w_a + r_de_imm;
                w_mw     = 1'b1;
            end
            default: begin
                w_ill   = 1'b1;
                w_store = '0;
            end
        endcase
    end

    // ID/EX: flush beats the hazard hold; stall freezes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_de_valid  <= 1'b0;
            r_de_pc     <= '0;
            r_de_opcode <= '0;
            r_de_funct  <= '0;
            r_de_rs     <= '0;
            r_de_rt     <= '0;
            r_de_rd     <= '0;
            r_de_rd1    <= '0;
            r_de_rd2    <= '0;
            r_de_imm    <= '0;
        end else if (!bus.stall) begin
            if (bus.flush) begin
                r_de_valid <= 1'b0;
            end else if (!w_hazard) begin
                r_de_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    r_de_pc     <= bus.id_pc;
                    r_de_opcode <= bus.id_opcode;
                    r_de_funct  <= bus.id_funct;
                    r_de_rs     <= bus.id_rs;
                    r_de_rt     <= bus.id_rt;
                    r_de_rd     <= bus.id_rd;
                    r_de_rd1    <= bus.id_rd1;
                    r_de_rd2    <= bus.id_rd2;
                    r_de_imm    <= bus.id_imm;
                end
            end
        end
    end

    // EX/MEM: bubbles are fully zeroed so no stale field leaks downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_em_valid     <= 1'b0;
            r_em_pc        <= '0;
            r_em_result    <= '0;
            r_em_store     <= '0;
            r_em_dest      <= '0;
            r_em_reg_write <= 1'b0;
            r_em_mem_read  <= 1'b0;
            r_em_mem_write <= 1'b0;
            r_em_illegal   <= 1'b0;
        end else if (!bus.stall) begin
            if (w_hazard || !r_de_valid) begin
                r_em_valid     <= 1'b0;
                r_em_pc        <= '0;
                r_em_result    <= '0;
                r_em_store     <= '0;
                r_em_dest      <= '0;
                r_em_reg_write <= 1'b0;
                r_em_mem_read  <= 1'b0;
                r_em_mem_write <= 1'b0;
                r_em_illegal   <= 1'b0;
            end else begin
                r_em_valid     <= 1'b1;
                r_em_pc        <= r_de_pc;
                r_em_result    <= w_result;
                r_em_store     <= w_store;
                r_em_dest      <= w_dest;
                r_em_reg_write <= w_rw;
                r_em_mem_read  <= w_mr;
                r_em_mem_write <= w_mw;
                r_em_illegal   <= w_ill;
            end
        end
    end

    assign bus.in_ready      = !bus.stall && !w_hazard;
    assign bus.ex_valid      = r_em_valid;
    assign bus.ex_pc         = r_em_pc;
    assign bus.ex_alu_result = r_em_result;
    assign bus.ex_store_data = r_em_store;
    assign bus.ex_dest_reg   = r_em_dest;
    assign bus.ex_reg_write  = r_em_reg_write;
    assign bus.ex_mem_read   = r_em_mem_read;
    assign bus.ex_mem_write  = r_em_mem_write;
    assign bus.ex_illegal    = r_em_illegal;
    assign bus.ex_hazard     = w_hazard;
endmodule

// File: tb/tb_stage_ex.sv
// Directed-vector bench for stage_ex: a table of per-cycle stimulus with hand-computed
// EX/MEM outputs, plus hand sequences for reset, latency and async reset mid-hazard.
module tb_stage_ex;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stage_ex_if #(.DATA_W(32), .REG_W(5)) bus ();
    stage_ex #(.DATA_W(32), .REG_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    typedef struct packed {
        logic        iv, st, fl;
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd;
        logic [31:0] a, b, imm;
        logic        wv;
        logic [4:0]  wr;
        logic [31:0] wd;
    } stim_t;

    typedef struct packed {
        logic        ev;
        logic [31:0] res, sd;
        logic [4:0]  dst;
        logic        rw, mr, mw, ill, hz, rdy;
    } exp_t;

    typedef struct packed {
        stim_t s;
        exp_t  e;
    } vec_t;

    localparam int NV = 33;
    vec_t tv [NV];
    int nvec = 0;
    int nerr = 0;

    function automatic stim_t ins(input logic [5:0] op, fn, input logic [4:0] rs, rt, rd,
                                  input logic [31:0] a, b, imm);
        stim_t s = '0;
        s.iv = 1'b1; s.op = op; s.fn = fn; s.rs = rs; s.rt = rt; s.rd = rd;
        s.a = a; s.b = b; s.imm = imm;
        return s;
    endfunction

    function automatic stim_t idle();
        stim_t s = '0;
        return s;
    endfunction

    function automatic stim_t wb(input stim_t si, input logic [4:0] r, input logic [31:0] d);
        stim_t s = si;
        s.wv = 1'b1; s.wr = r; s.wd = d;
        return s;
    endfunction

    function automatic stim_t ctl(input stim_t si, input logic st, input logic fl);
        stim_t s = si;
        s.st = st; s.fl = fl;
        return s;
    endfunction

    function automatic exp_t bub(input logic hz, input logic rdy);
        exp_t e = '0;
        e.hz = hz; e.rdy = rdy;
        return e;
    endfunction

    function automatic exp_t ex(input logic [31:0] res, sd, input logic [4:0] dst,
                                input logic rw, mr, mw, ill, hz, rdy);
        exp_t e;
        e.ev = 1'b1; e.res = res; e.sd = sd; e.dst = dst;
        e.rw = rw; e.mr = mr; e.mw = mw; e.ill = ill; e.hz = hz; e.rdy = rdy;
        return e;
    endfunction

    function automatic exp_t sample();
        exp_t g;
        g.ev = bus.ex_valid; g.res = bus.ex_alu_result; g.sd = bus.ex_store_data;
        g.dst = bus.ex_dest_reg; g.rw = bus.ex_reg_write; g.mr = bus.ex_mem_read;
        g.mw = bus.ex_mem_write; g.ill = bus.ex_illegal; g.hz = bus.ex_hazard;
        g.rdy = bus.in_ready;
        return g;
    endfunction

    task automatic drive(input stim_t s, input logic [31:0] pc);
        bus.in_valid = s.iv; bus.stall = s.st; bus.flush = s.fl; bus.id_pc = pc;
        bus.id_opcode = s.op; bus.id_funct = s.fn; bus.id_rs = s.rs; bus.id_rt = s.rt;
        bus.id_rd = s.rd; bus.id_rd1 = s.a; bus.id_rd2 = s.b; bus.id_imm = s.imm;
        bus.wb_valid = s.wv; bus.wb_reg = s.wr; bus.wb_data = s.wd;
    endtask

    task automatic check_out(input string name, input exp_t e);
        exp_t g = sample();
        nvec++;
        if (g !== e) begin
            nerr++;
            $display("FAIL %s: got v=%b res=%h sd=%h dst=%0d rw=%b mr=%b mw=%b ill=%b hz=%b rdy=%b; want v=%b res=%h sd=%h dst=%0d rw=%b mr=%b mw=%b ill=%b hz=%b rdy=%b",
                     name, g.ev, g.res, g.sd, g.dst, g.rw, g.mr, g.mw, g.ill, g.hz, g.rdy,
                     e.ev, e.res, e.sd, e.dst, e.rw, e.mr, e.mw, e.ill, e.hz, e.rdy);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    initial begin
        // R-type add $9,$8,$8 then dependent sub: EX/MEM bypass of rt
        tv[0]  = '{ins(6'h00, 6'h20, 5'd8, 5'd8, 5'd9, 32'd5, 32'd5, 32'd0), bub(1'b0, 1'b1)};
        tv[1]  = '{ins(6'h00, 6'h22, 5'd8, 5'd9, 5'd10, 32'd5, 32'd0, 32'd0),
                   ex(32'd10, 32'd5, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)};
        tv[2]  = '{idle(), ex(32'hFFFF_FFFB, 32'd10, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)};
        tv[3]  = '{idle(), bub(1'b0, 1'b1)};
        // lw $11,4($16) then add $13,$12,$11: one bubble, rt then from WB
        tv[4]  = '{ins(6'h23, 6'h00, 5'd16, 5'd11, 5'd0, 32'h100, 32'd0, 32'd4), bub(1'b0, 1'b1)};
        tv[5]  = '{ins(6'h00, 6'h20, 5'd12, 5'd11, 5'd13, 32'h20, 32'd0, 32'd0),
                   ex(32'h104, 32'd0, 5'd11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0)};
        tv[6]  = '{ins(6'h00, 6'h25, 5'd1, 5'd2, 5'd14, 32'd1, 32'd2, 32'd0), bub(1'b0, 1'b1)};
        tv[7]  = '{wb(ins(6'h00, 6'h25, 5'd1, 5'd2, 5'd14, 32'd1, 32'd2, 32'd0), 5'd11, 32'h55),
                   ex(32'h75, 32'h55, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)};
        tv[8]  = '{idle(), ex(32'd3, 32'd2, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)};
        tv[9]  = '{idle(), bub(1'b0, 1'b1)};
        // forward priority: EX/MEM (7) beats WB (3); then WB alone
        tv[10] = '{ins(6'h00, 6'h20, 5'd1, 5'd2, 5'd9, 32'd3, 32'd4, 32'd0), bub(1'b0, 1'b1)};
        tv[11] = '{ins(6'h00, 6'h24, 5'd9, 5'd9, 5'd15, 32'hFF, 32'hFF, 32'd0),
                   ex(32'd7, 32'd4, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)};
        tv[12] = '{wb(idle(), 5'd9, 32'd3), ex(32'd7, 32'd7, 5'd15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)};
        tv[13] = '{idle(), bub(1'b0, 1'b1)};
        tv[14] = '{ins(6'h00, 6'h24, 5'd9, 5'd9, 5'd15, 32'hFF, 32'hFF, 32'd0), bub(1'b0, 1'b1)};
        tv[15] = '{wb(idle(), 5'd9, 32'd3), ex(32'd3, 32'd3, 5'd15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)};
        // $0 is never forwarded from EX/MEM (0xDEAD) or WB
        tv[16] = '{ins(6'h00, 6'h20, 5'd1, 5'd2, 5'd0, 32'hDE00, 32'hAD, 32'd0), bub(1'b0, 1'b1)};
        tv[17] = '{ins(6'h00, 6'h25, 5'd0, 5'd0, 5'd12, 32'd0, 32'd0, 32'd0),
                   ex(32'hDEAD, 32'hAD, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)};
        tv[18] = '{wb(idle(), 5'd0, 32'hBEEF), ex(32'd0, 32'd0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)};
        // illegal opcode 0x3F, then illegal funct 0x21
        tv[19] = '{ins(6'h3F, 6'h20, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'd0), bub(1'b0, 1'b1)};
        tv[20] = '{ins(6'h00, 6'h21, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'd0),
                   ex(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1)};
        tv[21] = '{idle(), ex(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1)};
        // sw flushed on acceptance, then the same sw unflushed
        tv[22] = '{ctl(ins(6'h2B, 6'h00, 5'd4, 5'd5, 5'd0, 32'h200, 32'h77, 32'd8), 1'b0, 1'b1), bub(1'b0, 1'b1)};
        tv[23] = '{idle(), bub(1'b0, 1'b1)};
        tv[24] = '{ins(6'h2B, 6'h00, 5'd4, 5'd5, 5'd0, 32'h200, 32'h77, 32'd8), bub(1'b0, 1'b1)};
        tv[25] = '{idle(), ex(32'h208, 32'h77, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1)};
        // 3-cycle stall mid-stream with flush inside the stall
        tv[26] = '{ins(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'd0), bub(1'b0, 1'b1)};
        tv[27] = '{ins(6'h00, 6'h22, 5'd1, 5'd2, 5'd4, 32'd9, 32'd4, 32'd0),
                   ex(32'd3, 32'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)};
        tv[28] = '{ctl(ins(6'h00, 6'h25, 5'd1, 5'd2, 5'd5, 32'd1, 32'd1, 32'd0), 1'b1, 1'b0),
                   ex(32'd3, 32'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
        tv[29] = '{ctl(ins(6'h00, 6'h25, 5'd1, 5'd2, 5'd5, 32'd1, 32'd1, 32'd0), 1'b1, 1'b1),
                   ex(32'd3, 32'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
        tv[30] = '{ctl(idle(), 1'b1, 1'b0), ex(32'd3, 32'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
        tv[31] = '{idle(), ex(32'd5, 32'd4, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)};
        tv[32] = '{idle(), bub(1'b0, 1'b1)};

        drive(idle(), 32'd0);
        #2;
        check_out("reset_state", bub(1'b0, 1'b1));
        chk("reset_pc", bus.ex_pc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(tv[i].s, 32'h400 + 32'(i) * 32'd4);
            @(posedge clk);
            #1;
            check_out($sformatf("vec%0d", i), tv[i].e);
        end

        // accepted at edge N, visible after edge N+1 with its PC
        @(negedge clk);
        drive(ins(6'h00, 6'h20, 5'd1, 5'd2, 5'd6, 32'd10, 32'd20, 32'd0), 32'hABC);
        @(posedge clk);
        #1;
        chk("latency_n", {31'd0, bus.ex_valid}, 32'd0);
        @(negedge clk);
        drive(idle(), 32'd0);
        @(posedge clk);
        #1;
        chk("latency_pc", bus.ex_pc, 32'hABC);
        chk("latency_res", bus.ex_alu_result, 32'd30);

        // async reset while a load-use hazard is pending
        @(negedge clk);
        drive(ins(6'h23, 6'h00, 5'd16, 5'd11, 5'd0, 32'h100, 32'd0, 32'd4), 32'h500);
        @(negedge clk);
        drive(ins(6'h00, 6'h20, 5'd11, 5'd12, 5'd13, 32'd0, 32'd1, 32'd0), 32'h504);
        @(posedge clk);
        #1;
        chk("hazard_pre_rst", {31'd0, bus.ex_hazard}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_reset", bub(1'b0, 1'b1));
        chk("async_reset_pc", bus.ex_pc, 32'd0);
        @(negedge clk);
        drive(idle(), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_out("post_reset_bubble", bub(1'b0, 1'b1));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
